// File: rtl/peer_link_receiver_pkg.sv
// Shared definitions for the board-to-board player link receiver:
// button bit order, parameter defaults and link-state encoding.
package peer_link_receiver_pkg;

  localparam int unsigned NUM_BTNS   = 4;
  localparam int unsigned BTN_TOUCH  = 0;
  localparam int unsigned BTN_UP     = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_SELECT = 3;

  localparam int unsigned DEF_INVERTED_INPUT  = 1;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_DEBOUNCE_WIDTH  = 20;
  localparam int unsigned DEF_CLK_DIV_LOG2    = 4;
  localparam int unsigned DEF_LINK_TIMEOUT    = 1024;

  // Link acquisition: two consecutive divided-clock edges are needed before link_up.
  typedef enum logic [1:0] {
    LINK_DOWN  = 2'd0,
    LINK_ARMED = 2'd1,
    LINK_UP    = 2'd2
  } link_state_t;

  // Bits needed to hold values 0..value-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((bits < 32) && ((64'd1 << bits) < 64'(value))) bits++;
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/peer_link_receiver_if.sv
// Pin-side and Game_Engine-side signals of the peer link receiver.
interface peer_link_receiver_if;
  import peer_link_receiver_pkg::*;

  logic                peer_clock;
  logic                peer_reset_in;
  logic                peer_touch_in;
  logic                peer_up_in;
  logic                peer_down_in;
  logic                peer_select_in;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic                peer_in_reset;
  logic                link_up;
  logic                link_lost;

  // Peer header / consumer side
  modport master (
    output peer_clock, peer_reset_in, peer_touch_in, peer_up_in, peer_down_in, peer_select_in,
    input  btn_level, btn_press, peer_in_reset, link_up, link_lost
  );

  // Receiver side
  modport slave (
    input  peer_clock, peer_reset_in, peer_touch_in, peer_up_in, peer_down_in, peer_select_in,
    output btn_level, btn_press, peer_in_reset, link_up, link_lost
  );

endinterface

// File: rtl/button_debouncer.sv
// Per-button debouncer: a level is accepted once the sample has differed from
// the stable value for DEBOUNCE_CYCLES consecutive cycles; press pulses on 0->1.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DEBOUNCE_WIDTH  = 20
) (
  input  logic clock,
  input  logic resetApp,
  input  logic clear,
  input  logic sample,
  output logic level,
  output logic press
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [DEBOUNCE_WIDTH-1:0] cnt_q;
  logic                      stable_q;

  // Clear holds the button released so a held key must re-qualify after the gate opens.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else if (clear) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sample;
        cnt_q    <= '0;
        press    <= sample;
      end else begin
        cnt_q <= cnt_q + DEBOUNCE_WIDTH'(1);
      end
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/peer_link_receiver.sv
// Receive end of the board-to-board player link: synchronises the peer's GPIO
// lines, tracks peer clock health and debounces the four peer buttons.
module peer_link_receiver
  import peer_link_receiver_pkg::*;
#(
  parameter int unsigned INVERTED_INPUT  = DEF_INVERTED_INPUT,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DEBOUNCE_WIDTH  = DEF_DEBOUNCE_WIDTH,
  parameter int unsigned CLK_DIV_LOG2    = DEF_CLK_DIV_LOG2,
  parameter int unsigned LINK_TIMEOUT    = DEF_LINK_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 resetApp,
  peer_link_receiver_if.slave  link
);

  localparam int unsigned NUM_LINES = NUM_BTNS + 1;
  localparam int unsigned RST_LINE  = NUM_BTNS;
  localparam int unsigned DIV_W     = CLK_DIV_LOG2 + 1;
  localparam int unsigned WDOG_W    = clog2(LINK_TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(LINK_TIMEOUT - 1);
  localparam logic              INV_BIT  = 1'(INVERTED_INPUT);

  logic [NUM_LINES-1:0]                  raw_c;
  logic [NUM_LINES-1:0][SYNC_STAGES-1:0] line_sync;
  logic [NUM_BTNS-1:0]                   btn_sample_c;
  logic                                  peer_rst_q;
  logic [DIV_W-1:0]                      peer_div;
  logic [SYNC_STAGES-1:0]                act_sync;
  logic                                  act_d;
  logic                                  activity_c;
  logic                                  timeout_c;
  link_state_t                           state_q, state_nxt;
  logic [WDOG_W-1:0]                     wdog_q, wdog_nxt;
  logic                                  link_up_q, link_up_nxt;
  logic                                  link_lost_q, link_lost_nxt;
  logic                                  gate_c;
  logic [NUM_BTNS-1:0]                   btn_level_q;
  logic [NUM_BTNS-1:0]                   btn_press_q;

  // Normalise every incoming line to active-high.
  always_comb begin
    raw_c             = '0;
    raw_c[BTN_TOUCH]  = link.peer_touch_in;
    raw_c[BTN_UP]     = link.peer_up_in;
    raw_c[BTN_DOWN]   = link.peer_down_in;
    raw_c[BTN_SELECT] = link.peer_select_in;
    raw_c[RST_LINE]   = link.peer_reset_in;
    raw_c             = raw_c ^ {NUM_LINES{INV_BIT}};
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      line_sync <= '0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        line_sync[i] <= {line_sync[i][SYNC_STAGES-2:0], raw_c[i]};
      end
    end
  end

  always_comb begin
    btn_sample_c = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      btn_sample_c[i] = line_sync[i][SYNC_STAGES-1];
    end
  end

  assign peer_rst_q = line_sync[RST_LINE][SYNC_STAGES-1];

  // Peer-domain divider; only its MSB crosses into the local domain.
  always_ff @(posedge link.peer_clock or posedge resetApp) begin
    if (resetApp) begin
      peer_div <= '0;
    end else begin
      peer_div <= peer_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      act_sync <= '0;
      act_d    <= 1'b0;
    end else begin
      act_sync <= {act_sync[SYNC_STAGES-2:0], peer_div[DIV_W-1]};
      act_d    <= act_sync[SYNC_STAGES-1];
    end
  end

  assign activity_c = act_sync[SYNC_STAGES-1] ^ act_d;
  assign timeout_c  = (wdog_q == WDOG_MAX);

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_q     <= LINK_DOWN;
      wdog_q      <= '0;
      link_up_q   <= 1'b0;
      link_lost_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      wdog_q      <= wdog_nxt;
      link_up_q   <= link_up_nxt;
      link_lost_q <= link_lost_nxt;
    end
  end

  // Watchdog saturates at LINK_TIMEOUT-1; a saturated watchdog drops the link.
  always_comb begin
    state_nxt     = state_q;
    wdog_nxt      = wdog_q;
    link_lost_nxt = 1'b0;

    if (activity_c) begin
      wdog_nxt = '0;
    end else if (!timeout_c) begin
      wdog_nxt = wdog_q + WDOG_W'(1);
    end

    case (state_q)
      LINK_DOWN: begin
        if (activity_c) state_nxt = LINK_ARMED;
      end
      LINK_ARMED: begin
        if (activity_c) begin
          state_nxt = LINK_UP;
        end else if (timeout_c) begin
          state_nxt = LINK_DOWN;
        end
      end
      LINK_UP: begin
        if (!activity_c && timeout_c) begin
          state_nxt     = LINK_DOWN;
          link_lost_nxt = 1'b1;
        end
      end
      default: state_nxt = LINK_DOWN;
    endcase

    link_up_nxt = (state_nxt == LINK_UP);
  end

  assign gate_c = ~link_up_q | peer_rst_q;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DEBOUNCE_WIDTH  (DEBOUNCE_WIDTH)
    ) u_debouncer (
      .clock    (clock),
      .resetApp (resetApp),
      .clear    (gate_c),
      .sample   (btn_sample_c[g]),
      .level    (btn_level_q[g]),
      .press    (btn_press_q[g])
    );
  end

  assign link.btn_level     = btn_level_q;
  assign link.btn_press     = btn_press_q;
  assign link.peer_in_reset = peer_rst_q;
  assign link.link_up       = link_up_q;
  assign link.link_lost     = link_lost_q;

endmodule

// File: tb/tb_peer_link_receiver.sv
// Self-checking bench for peer_link_receiver: vector table, random buttons
// against a history-based debounce model, and hand-written link/reset sequences.
module tb_peer_link_receiver;
  import peer_link_receiver_pkg::*;

  localparam int unsigned DEB  = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 64;

  typedef struct {
    logic [3:0] mask;
    int         hold;
    logic [3:0] exp_seen;
  } vec_t;

  logic clock    = 1'b0;
  logic resetApp = 1'b1;
  logic peer_run = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  vec_t       vecs [6];
  logic [3:0] hist [$];
  logic [3:0] pipe [$];
  int         since [4];
  logic [3:0] m_level;
  logic [3:0] m_press;

  peer_link_receiver_if link();

  peer_link_receiver #(
    .INVERTED_INPUT  (1),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .DEBOUNCE_WIDTH  (5),
    .CLK_DIV_LOG2    (1),
    .LINK_TIMEOUT    (TMO)
  ) dut (
    .clock    (clock),
    .resetApp (resetApp),
    .link     (link)
  );

  always #10 clock = ~clock;

  // Peer clock at 50 MHz, phase-shifted against the local clock, gated by peer_run.
  initial begin
    link.peer_clock = 1'b0;
    forever begin
      wait (peer_run);
      #3;
      while (peer_run) #10 link.peer_clock = ~link.peer_clock;
      link.peer_clock = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [3:0] pressed);
    link.peer_touch_in  = ~pressed[0];
    link.peer_up_in     = ~pressed[1];
    link.peer_down_in   = ~pressed[2];
    link.peer_select_in = ~pressed[3];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_link(output int n);
    n = 0;
    while (link.link_up !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // A button changes once its last DEB samples all disagree with the current level,
  // counting only samples taken after its previous change.
  task automatic model_step(input logic [3:0] s);
    bit all_diff;
    hist.push_back(s);
    if (hist.size() > DEB) void'(hist.pop_front());
    m_press = 4'b0;
    for (int i = 0; i < 4; i++) begin
      since[i]++;
      if (since[i] >= int'(DEB) && hist.size() == DEB) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[i] = ~m_level[i];
          m_press[i] = m_level[i];
          since[i]   = 0;
        end
      end
    end
  endtask

  initial begin : main
    logic [3:0] acc;
    logic [3:0] seen;
    logic [3:0] first_press;
    logic [3:0] cur;
    logic [3:0] samp;
    logic [3:0] pmask;
    int         n, cnt, first, lat, presses, link_c, press_c;
    int         hold_left [4];
    logic       lost_acc;

    set_btns(4'b0000);
    link.peer_reset_in = 1'b1;
    vecs[0] = '{4'b0001, 30, 4'b0001};
    vecs[1] = '{4'b0010, 10, 4'b0000};
    vecs[2] = '{4'b0100, 15, 4'b0000};
    vecs[3] = '{4'b1000, 16, 4'b1000};
    vecs[4] = '{4'b0011, 20, 4'b0011};
    vecs[5] = '{4'b1111, 40, 4'b1111};

    repeat (3) @(posedge clock);
    #1;
    check("reset_btn_level", 32'(link.btn_level), 32'd0);
    check("reset_btn_press", 32'(link.btn_press), 32'd0);
    check("reset_peer_in_reset", 32'(link.peer_in_reset), 32'd0);
    check("reset_link_up", 32'(link.link_up), 32'd0);
    check("reset_link_lost", 32'(link.link_lost), 32'd0);

    resetApp = 1'b0;
    acc = 4'b0;
    repeat (1000) begin
      tick();
      acc = acc | {2'b00, link.link_up, link.link_lost};
    end
    check("idle_no_link", 32'(acc), 32'd0);

    peer_run = 1'b1;
    wait_link(n);
    check("acquire_link_up", 32'(link.link_up), 32'd1);
    check("acquire_time_ok", 32'(n <= 16), 32'd1);

    peer_run = 1'b0;
    cnt = 0;
    first = -1;
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (link.link_lost === 1'b1) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    check("loss_pulse_count", 32'(cnt), 32'd1);
    check("loss_timing_ok", 32'(first >= 60 && first <= 75), 32'd1);
    check("loss_link_down", 32'(link.link_up), 32'd0);

    peer_run = 1'b1;
    wait_link(n);
    check("reacquire_link_up", 32'(link.link_up), 32'd1);
    repeat (10) tick();

    // Vector table: press mask held for a number of raw cycles, then released.
    for (int r = 0; r < 6; r++) begin
      seen = 4'b0;
      first_press = 4'b0;
      presses = 0;
      lat = -1;
      set_btns(vecs[r].mask);
      for (int c = 1; c <= vecs[r].hold + 50; c++) begin
        tick();
        if (c == vecs[r].hold) set_btns(4'b0000);
        seen = seen | link.btn_level;
        if (lat < 0 && link.btn_level != 4'b0) lat = c;
        if (first_press == 4'b0) first_press = link.btn_press;
        for (int i = 0; i < 4; i++) presses += int'(link.btn_press[i]);
      end
      check($sformatf("vec%0d_seen", r), 32'(seen), 32'(vecs[r].exp_seen));
      check($sformatf("vec%0d_first_press", r), 32'(first_press), 32'(vecs[r].exp_seen));
      check($sformatf("vec%0d_press_count", r), 32'(presses), 32'($countones(vecs[r].exp_seen)));
      check($sformatf("vec%0d_final_level", r), 32'(link.btn_level), 32'd0);
      if (vecs[r].exp_seen != 4'b0) check($sformatf("vec%0d_latency", r), 32'(lat), 32'(SYNC + DEB));
    end

    // Random buttons against the history model.
    hist.delete();
    repeat (DEB) hist.push_back(4'b0);
    pipe.delete();
    repeat (SYNC) pipe.push_back(4'b0);
    for (int i = 0; i < 4; i++) begin
      since[i] = DEB;
      hold_left[i] = $urandom_range(40, 3);
    end
    m_level = 4'b0;
    cur = 4'b0;
    lost_acc = 1'b0;
    for (int c = 0; c < 1300; c++) begin
      if (c >= 1240) begin
        cur = 4'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (hold_left[i] == 0) begin
            cur[i] = ~cur[i];
            hold_left[i] = $urandom_range(40, 3);
          end else begin
            hold_left[i]--;
          end
        end
      end
      set_btns(cur);
      @(posedge clock);
      samp = pipe.pop_front();
      pipe.push_back(cur);
      model_step(samp);
      #1;
      check("rand_level", 32'(link.btn_level), 32'(m_level));
      check("rand_press", 32'(link.btn_press), 32'(m_press));
      lost_acc = lost_acc | link.link_lost;
    end
    check("rand_no_link_lost", 32'(lost_acc), 32'd0);
    check("rand_link_still_up", 32'(link.link_up), 32'd1);

    // Select held across a peer reset.
    set_btns(4'b1000);
    n = 0;
    while (link.btn_level[3] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("sel_level_before_reset", 32'(link.btn_level[3]), 32'd1);
    link.peer_reset_in = 1'b0;
    acc = 4'b0;
    repeat (4) begin
      tick();
      acc = acc | link.btn_press;
    end
    check("peer_in_reset_high", 32'(link.peer_in_reset), 32'd1);
    check("gated_level_zero", 32'(link.btn_level), 32'd0);
    repeat (20) begin
      tick();
      acc = acc | link.btn_press | link.btn_level;
    end
    check("gated_no_press", 32'(acc), 32'd0);
    link.peer_reset_in = 1'b1;
    n = 0;
    while (link.peer_in_reset !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("peer_in_reset_low", 32'(link.peer_in_reset), 32'd0);
    cnt = 0;
    first = -1;
    acc = 4'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      acc = acc | link.btn_press;
      if (link.btn_press[3] === 1'b1) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    check("release_press_count", 32'(cnt), 32'd1);
    check("release_press_mask", 32'(acc), 32'd8);
    check("release_press_delay_ok", 32'(first >= 15 && first <= 17), 32'd1);
    set_btns(4'b0000);
    repeat (30) tick();

    // resetApp asserted between clock edges while two buttons are held.
    set_btns(4'b0011);
    n = 0;
    while (link.btn_level !== 4'b0011 && n < 40) begin
      tick();
      n++;
    end
    check("pre_reset_level", 32'(link.btn_level), 32'd3);
    @(posedge clock);
    #5;
    resetApp = 1'b1;
    #1;
    check("async_rst_level", 32'(link.btn_level), 32'd0);
    check("async_rst_press", 32'(link.btn_press), 32'd0);
    check("async_rst_peer_in_reset", 32'(link.peer_in_reset), 32'd0);
    check("async_rst_link_up", 32'(link.link_up), 32'd0);
    check("async_rst_link_lost", 32'(link.link_lost), 32'd0);
    repeat (3) tick();
    resetApp = 1'b0;
    link_c = -1;
    press_c = -1;
    pmask = 4'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (link_c < 0 && link.link_up === 1'b1) link_c = c;
      if (press_c < 0 && link.btn_press != 4'b0) begin
        press_c = c;
        pmask = link.btn_press;
      end
    end
    check("post_rst_link_reacquired", 32'(link_c > 0), 32'd1);
    check("post_rst_press_mask", 32'(pmask), 32'd3);
    check("post_rst_press_after_debounce", 32'(press_c - link_c >= 15 && press_c - link_c <= 18), 32'd1);
    set_btns(4'b0000);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
